// File: rtl/ahb_arbiter.sv
// ahb_arbiter: central AHB arbiter for up to 16 masters.
// Grants the bus round-robin and honours locked sequences. A granted
// fixed-length burst is never broken. A master that gets a SPLIT response
// is masked until its hsplit bit is set.
// Ports:
//   hclk, hresetn            bus clock, synchronous active-low reset
//   hbusreq, hlock           per-master request / locked-access request
//   hready, htrans, hburst   current transfer state (drives beat counter)
//   hresp, hsplit            slave response and split-resume vector
//   hgrant, hmaster          registered one-hot grant and address-phase owner
//   hmastlock                registered locked-address-phase flag
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic                   hready,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic [1:0]             hresp,
    input  logic [15:0]            hsplit,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [3:0]             hmaster,
    output logic                   hmastlock
);

    localparam logic [3:0] DEF_IDX = 4'(DEFAULT_MASTER);

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [3:0] idx);
        logic [NUM_MASTERS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (idx == 4'(i)) v[i] = 1'b1;
        return v;
    endfunction

    logic [3:0]             grant_idx, grant_nxt;
    logic [3:0]             cnt, cnt_nxt, burst_load;
    logic [3:0]             data_master;
    logic [NUM_MASTERS-1:0] split_mask, split_mask_nxt, split_set, eligible;
    logic                   owner_req, owner_lock, owner_masked;
    logic                   arb_edge, lock_hold, found;
    logic [4:0]             cand;
    logic                   unused_hsplit;

    assign unused_hsplit = ^hsplit;

    // Beat counter: remaining beats of the burst in progress.
    always_comb begin
        case (hburst)
            3'd0, 3'd1: burst_load = 4'd0;
            3'd2, 3'd3: burst_load = 4'd3;
            3'd4, 3'd5: burst_load = 4'd7;
            default:    burst_load = 4'd15;
        endcase
        cnt_nxt = cnt;
        if (hready) begin
            // Second cycle of RETRY/SPLIT ends the burst early.
            if (hresp[1])
                cnt_nxt = 4'd0;
            else if (htrans == 2'b10)
                cnt_nxt = burst_load;
            else if (htrans == 2'b11 && cnt != 4'd0)
                cnt_nxt = cnt - 4'd1;
        end
    end

    // Set (second SPLIT cycle) takes priority over a same-cycle hsplit clear.
    always_comb begin
        split_set = '0;
        if (hready && hresp == 2'b11)
            split_set = onehot(data_master);
        split_mask_nxt = (split_mask & ~hsplit[NUM_MASTERS-1:0]) | split_set;
    end

    always_comb begin
        owner_req    = 1'b0;
        owner_lock   = 1'b0;
        owner_masked = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_idx == 4'(i)) begin
                owner_req    = hbusreq[i];
                owner_lock   = hlock[i];
                owner_masked = split_mask[i];
            end
        end
    end

    assign arb_edge  = hready && (cnt_nxt == 4'd0);
    assign lock_hold = owner_req && owner_lock && !owner_masked;
    assign eligible  = hbusreq & ~split_mask;

    // Round-robin scan starting after the current owner; the owner itself
    // is visited last (k == NUM_MASTERS wraps back to grant_idx).
    always_comb begin
        grant_nxt = grant_idx;
        found     = 1'b0;
        cand      = '0;
        if (arb_edge && !lock_hold) begin
            for (int k = 1; k <= NUM_MASTERS; k++) begin
                cand = 5'(grant_idx) + 5'(k);
                if (cand >= 5'(NUM_MASTERS))
                    cand = cand - 5'(NUM_MASTERS);
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (!found && cand == 5'(i) && eligible[i]) begin
                        grant_nxt = 4'(i);
                        found     = 1'b1;
                    end
                end
            end
            if (!found)
                grant_nxt = DEF_IDX;
        end
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            grant_idx   <= DEF_IDX;
            hgrant      <= onehot(DEF_IDX);
            hmaster     <= DEF_IDX;
            hmastlock   <= 1'b0;
            cnt         <= 4'd0;
            split_mask  <= '0;
            data_master <= DEF_IDX;
        end else begin
            split_mask <= split_mask_nxt;
            if (hready) begin
                cnt         <= cnt_nxt;
                grant_idx   <= grant_nxt;
                hgrant      <= onehot(grant_nxt);
                hmaster     <= grant_idx;
                hmastlock   <= owner_lock & owner_req;
                data_master <= hmaster;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hresetn)
            assert (int'(grant_idx) < NUM_MASTERS);
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter (NUM_MASTERS=4, DEFAULT_MASTER=0).
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns after the
// edge they result from.
module tb_ahb_arbiter;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [3:0]  hbusreq, hlock;
    logic        hready;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [1:0]  hresp;
    logic [15:0] hsplit;
    logic [3:0]  hgrant;
    logic [3:0]  hmaster;
    logic        hmastlock;

    int errors = 0;
    int checks = 0;

    ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
        .hclk(hclk), .hresetn(hresetn), .hbusreq(hbusreq), .hlock(hlock),
        .hready(hready), .htrans(htrans), .hburst(hburst), .hresp(hresp),
        .hsplit(hsplit), .hgrant(hgrant), .hmaster(hmaster), .hmastlock(hmastlock)
    );

    always #5 hclk = ~hclk;

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic test_reset();
        hresetn = 1'b0; hbusreq = 4'b0000; hlock = 4'b0000; hready = 1'b1;
        htrans = 2'b00; hburst = 3'd0; hresp = 2'b00; hsplit = 16'h0;
        step(); step();
        checks++; if (hgrant !== 4'b0001) begin errors++; $display("FAIL reset_hgrant: got %b want 0001", hgrant); end
        checks++; if (hmaster !== 4'd0) begin errors++; $display("FAIL reset_hmaster: got %0d want 0", hmaster); end
        checks++; if (hmastlock !== 1'b0) begin errors++; $display("FAIL reset_hmastlock: got %b want 0", hmastlock); end
        hresetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (hgrant !== 4'b0001) begin errors++; $display("FAIL idle_hgrant[%0d]: got %b want 0001", i, hgrant); end
            checks++; if (hmaster !== 4'd0) begin errors++; $display("FAIL idle_hmaster[%0d]: got %0d want 0", i, hmaster); end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        logic [3:0] exp_m [4] = '{4'd0, 4'd1, 4'd3, 4'd1};
        hbusreq = 4'b1010; htrans = 2'b10; hburst = 3'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (hgrant !== exp_g[i]) begin errors++; $display("FAIL rr_hgrant[%0d]: got %b want %b", i, hgrant, exp_g[i]); end
            checks++; if (hmaster !== exp_m[i]) begin errors++; $display("FAIL rr_hmaster[%0d]: got %0d want %0d", i, hmaster, exp_m[i]); end
        end
    endtask

    task automatic test_burst();
        logic [3:0] exp_g;
        hbusreq = 4'b0100; htrans = 2'b00;
        step(); step();
        checks++; if (hgrant !== 4'b0100 || hmaster !== 4'd2) begin errors++; $display("FAIL burst_setup: got %b/%0d want 0100/2", hgrant, hmaster); end
        hbusreq = 4'b0110; htrans = 2'b10; hburst = 3'd5;
        step();
        checks++; if (hgrant !== 4'b0100) begin errors++; $display("FAIL burst_nonseq_hgrant: got %b want 0100", hgrant); end
        htrans = 2'b11;
        for (int i = 1; i <= 7; i++) begin
            if (i == 4) begin
                hready = 1'b0;
                for (int w = 0; w < 2; w++) begin
                    step();
                    checks++; if (hgrant !== 4'b0100 || hmaster !== 4'd2) begin errors++; $display("FAIL burst_wait[%0d]: got %b/%0d want 0100/2", w, hgrant, hmaster); end
                end
                hready = 1'b1;
            end
            step();
            exp_g = (i == 7) ? 4'b0010 : 4'b0100;
            checks++; if (hgrant !== exp_g) begin errors++; $display("FAIL burst_seq_hgrant[%0d]: got %b want %b", i, hgrant, exp_g); end
            checks++; if (hmaster !== 4'd2) begin errors++; $display("FAIL burst_seq_hmaster[%0d]: got %0d want 2", i, hmaster); end
        end
        hbusreq = 4'b0010; htrans = 2'b00;
        step();
        checks++; if (hgrant !== 4'b0010 || hmaster !== 4'd1) begin errors++; $display("FAIL burst_handover: got %b/%0d want 0010/1", hgrant, hmaster); end
    endtask

    task automatic test_lock();
        hbusreq = 4'b1001; hlock = 4'b1000; htrans = 2'b00;
        step();
        checks++; if (hgrant !== 4'b1000) begin errors++; $display("FAIL lock_grant: got %b want 1000", hgrant); end
        htrans = 2'b10; hburst = 3'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (hgrant !== 4'b1000) begin errors++; $display("FAIL lock_hold_hgrant[%0d]: got %b want 1000", i, hgrant); end
            checks++; if (hmaster !== 4'd3 || hmastlock !== 1'b1) begin errors++; $display("FAIL lock_hold_owner[%0d]: got %0d/%b want 3/1", i, hmaster, hmastlock); end
        end
        hbusreq = 4'b0001; hlock = 4'b0000; htrans = 2'b00;
        step();
        checks++; if (hgrant !== 4'b0001 || hmastlock !== 1'b0) begin errors++; $display("FAIL lock_release: got %b/%b want 0001/0", hgrant, hmastlock); end
        step();
        checks++; if (hmaster !== 4'd0) begin errors++; $display("FAIL lock_release_hmaster: got %0d want 0", hmaster); end
    endtask

    task automatic test_split();
        hbusreq = 4'b0010;
        step(); step(); step();
        checks++; if (hgrant !== 4'b0010 || hmaster !== 4'd1) begin errors++; $display("FAIL split_setup: got %b/%0d want 0010/1", hgrant, hmaster); end
        hbusreq = 4'b0011; hresp = 2'b11; hready = 1'b0;
        step();
        hready = 1'b1;
        step();
        checks++; if (hgrant !== 4'b0001) begin errors++; $display("FAIL split_edge_hgrant: got %b want 0001", hgrant); end
        hresp = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (hgrant !== 4'b0001) begin errors++; $display("FAIL split_masked_hgrant[%0d]: got %b want 0001", i, hgrant); end
        end
        hsplit = 16'h0002;
        step();
        checks++; if (hgrant !== 4'b0001) begin errors++; $display("FAIL split_pulse_hgrant: got %b want 0001", hgrant); end
        hsplit = 16'h0000;
        step();
        checks++; if (hgrant !== 4'b0010) begin errors++; $display("FAIL split_resume_hgrant: got %b want 0010", hgrant); end
    endtask

    task automatic test_reset_mid_burst();
        hresetn = 1'b0; hbusreq = 4'b0000; htrans = 2'b00;
        step();
        hresetn = 1'b1; hbusreq = 4'b0100;
        step(); step(); step();
        hresp = 2'b11; hready = 1'b0;
        step();
        hready = 1'b1;
        step();
        hresp = 2'b00; hbusreq = 4'b0001;
        step(); step();
        checks++; if (dut.split_mask !== 4'b0100) begin errors++; $display("FAIL rst_mid_setup_mask: got %b want 0100", dut.split_mask); end
        htrans = 2'b10; hburst = 3'd7;
        step();
        htrans = 2'b11;
        step(); step(); step();
        checks++; if (dut.cnt !== 4'd12 || hgrant !== 4'b0001) begin errors++; $display("FAIL rst_mid_setup_cnt: got %0d/%b want 12/0001", dut.cnt, hgrant); end
        hresetn = 1'b0;
        step();
        checks++; if (hgrant !== 4'b0001 || hmaster !== 4'd0 || hmastlock !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: got %b/%0d/%b want 0001/0/0", hgrant, hmaster, hmastlock); end
        checks++; if (dut.cnt !== 4'd0 || dut.split_mask !== 4'b0000 || dut.data_master !== 4'd0) begin errors++; $display("FAIL rst_mid_state: got cnt=%0d mask=%b dm=%0d want 0/0000/0", dut.cnt, dut.split_mask, dut.data_master); end
        hresetn = 1'b1; htrans = 2'b00; hbusreq = 4'b0100;
        step();
        checks++; if (hgrant !== 4'b0100) begin errors++; $display("FAIL rst_mid_after_hgrant: got %b want 0100", hgrant); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst();
        test_lock();
        test_split();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
